// File: rtl/unstriping_pkg.sv
// rtl/unstriping_pkg.sv - shared types and helpers for the N-lane unstriper
// Contents:
//   state_t     : merge FSM states (IDLE = waiting for lane 0 alignment, RUN = merging)
//   MAX_LANES   : largest supported lane count
//   lane_idx_w  : bit width needed to hold a lane index
package unstriping_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_LANES = 8;

    // Width of a lane index; never less than one bit.
    function automatic int lane_idx_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/unstriping_lane_fifo.sv
// rtl/unstriping_lane_fifo.sv - per-lane elastic FIFO absorbing inter-lane skew
// Ports:
//   clk, reset        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   : write request and word
//   pop               : read request (ignored while empty)
//   head              : word at the read pointer (valid when !empty)
//   full, empty       : occupancy flags
//   count             : occupancy, 0..DEPTH
module unstriping_lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are power-of-two sized and wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/unstriping_nlane.sv
// rtl/unstriping_nlane.sv - merges N striped lanes back into one round-robin word stream
// Optional feature macro: UNSTRIPE_WORD_CNT_EN (adds word_count output)
// Ports:
//   clk_2f      : single clock at the output word rate
//   reset       : synchronous active-high reset, flushes all lane FIFOs
//   valid_in    : per-lane word strobe
//   lane_data   : lane i word at [i*WIDTH +: WIDTH]
//   data_out    : merged word (registered, holds when not valid)
//   valid_out   : data_out carries a new word this cycle
//   lane_full   : per-lane FIFO full flag
//   overflow    : sticky, a word was dropped on a full lane
//   ovf_lane    : lane of the first drop
//   word_count  : (UNSTRIPE_WORD_CNT_EN only) number of valid_out cycles, wrapping
module unstriping_nlane
    import unstriping_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4
) (
    input  logic                       clk_2f,
    input  logic                       reset,
    input  logic [N_LANES-1:0]         valid_in,
    input  logic [N_LANES*WIDTH-1:0]   lane_data,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic [N_LANES-1:0]         lane_full,
    output logic                       overflow,
    output logic [$clog2(N_LANES)-1:0] ovf_lane
`ifdef UNSTRIPE_WORD_CNT_EN
    ,
    output logic [31:0]                word_count
`endif
);

    localparam int LW = lane_idx_w(N_LANES);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t           r_state;
    logic [LW-1:0]    r_rd_ptr;

    logic [WIDTH-1:0] w_head  [N_LANES];
    logic [CW-1:0]    w_count [N_LANES];
    logic [N_LANES-1:0] w_push;
    logic [N_LANES-1:0] w_pop;
    logic [N_LANES-1:0] w_full;
    logic [N_LANES-1:0] w_empty;
    logic [N_LANES-1:0] w_drop;
    logic             w_any_drop;
    logic [LW-1:0]    w_first_drop;
    logic             w_emit;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        // Until lane 0 delivers its first word the lanes are not aligned,
        // so other lanes' words are discarded.
        assign w_push[i]    = valid_in[i] && ((r_state == RUN) || (i == 0));
        assign w_pop[i]     = (r_state == RUN) && (r_rd_ptr == LW'(i)) && !w_empty[i];
        assign w_drop[i]    = w_push[i] && w_full[i] && !w_pop[i];
        assign lane_full[i] = (w_count[i] == CW'(DEPTH));

        unstriping_lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk_2f),
            .reset     (reset),
            .push      (w_push[i]),
            .push_data (lane_data[i*WIDTH +: WIDTH]),
            .pop       (w_pop[i]),
            .head      (w_head[i]),
            .full      (w_full[i]),
            .empty     (w_empty[i]),
            .count     (w_count[i])
        );
    end

    // Lowest-index drop wins when several lanes overflow together.
    always_comb begin
        w_any_drop   = |w_drop;
        w_first_drop = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (w_drop[i]) begin
                w_first_drop = LW'(i);
            end
        end
    end

    // Strict round-robin: stall on an empty lane rather than skipping it.
    assign w_emit = w_pop[r_rd_ptr];

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rd_ptr  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            ovf_lane  <= '0;
        end else begin
            if ((r_state == IDLE) && valid_in[0]) begin
                r_state <= RUN;
            end

            valid_out <= w_emit;
            if (w_emit) begin
                data_out <= w_head[r_rd_ptr];
                r_rd_ptr <= (r_rd_ptr == LW'(N_LANES - 1)) ? '0 : r_rd_ptr + 1'b1;
            end

            if (w_any_drop) begin
                overflow <= 1'b1;
                if (!overflow) begin
                    ovf_lane <= w_first_drop;
                end
            end
        end
    end

`ifdef UNSTRIPE_WORD_CNT_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_word_count <= '0;
        end else if (valid_out) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule
